adder_tree_accumulator: RTL and testbench
=========================================

Name: adder_tree_accumulator

Overview:
Temporal accumulator directly downstream of the final adder tree stage. It takes the single root sum per cycle and accumulates a group of beats delimited by first/last flags, for example the partial dot products over input-channel tiles. It then applies an arithmetic right shift plus width reduction and presents the result on a valid/ready output register. The adder tree cannot stall, so the block never back-pressures its input. It reports output overrun and protocol errors as sticky flags.

Parameters:
IN_WIDTH, 38, width of signed root sum from the adder tree
ACC_WIDTH, 48, signed accumulator width; must be >= IN_WIDTH
OUT_WIDTH, 32, signed result width; must be <= ACC_WIDTH
OUT_SHIFT, 0, arithmetic right shift applied at emission, 0..ACC_WIDTH-1
CNT_WIDTH, 16, width of beat counter

Ports:
clk  in  1  clock, all state on rising edge
rst_in  in  1  synchronous reset, active-high
sum_in  in  IN_WIDTH (signed)  root sum from adder tree
sum_valid_in  in  1  sum_in carries a valid beat this cycle
sum_first_in  in  1  beat starts a new group (qualified by valid)
sum_last_in  in  1  beat ends the group (qualified by valid)
out  out  OUT_WIDTH (signed)  accumulated, shifted, reduced result
out_valid  out  1  out holds an unconsumed result
out_ready  in  1  consumer accepts out this cycle
beat_count_out  out  CNT_WIDTH  beats in current or last completed group
busy_out  out  1  out_valid && !out_ready, advisory stall hint for upstream control
overrun_err_out  out  1  sticky: result dropped because output register full
protocol_err_out  out  1  sticky: first/last sequencing violated

Behaviour:
- Reset: sync, active-high. Only clk and rst_in are fixed: one clock, synchronous active-high reset.
- Reset values: state=IDLE, acc=0, out=0, out_valid=0, beat_count_out=0, both error flags=0. Reset mid-group discards the partial sum and any pending output.
- Sign handling: sum_in is sign-extended to ACC_WIDTH. Accumulation wraps modulo 2^ACC_WIDTH. There is no accumulator saturation; the user sizes ACC_WIDTH.
- FSM, two states: IDLE (no open group) and ACCUM (group open).
- IDLE, valid&first&last: single-beat group, emit sign-extended sum_in, count=1, stay IDLE.
- IDLE, valid&first&!last: acc<=sum_in, count<=1, go to ACCUM.
- IDLE, valid&!first: beat discarded, protocol_err set, stay IDLE.
- ACCUM, valid&!first&!last: acc<=acc+sum_in, count+=1.
- ACCUM, valid&!first&last: emit acc+sum_in, count+=1, go to IDLE.
- ACCUM, valid&first: protocol_err set, partial discarded, beat treated as a fresh first (same rules as IDLE).
- Any state, !valid: no change; first/last are ignored.
- Beat counter saturates at 2^CNT_WIDTH-1 and does not wrap. beat_count_out holds its value until the next first.
- Emission: result = (final acc) >>> OUT_SHIFT, arithmetic, then width-reduced to OUT_WIDTH (see Optional Feature).
- Latency: last beat sampled at edge t; out/out_valid update at edge t, visible in cycle t+1. The input can take a new first in the very next cycle.
- Output register: loaded on emission if out_valid==0, or if out_valid&&out_ready in the same cycle (simultaneous consume and load: new data, out_valid stays 1).
- Output register full and not consumed at emission: new result dropped, register unchanged, overrun_err set.
- out_valid&&out_ready without emission clears out_valid. out is held stable while out_valid && !out_ready.
- Error flags clear only on reset.

Optional Feature:
Macro ACCUM_OUT_SATURATE_EN.
- Defined: shifted value is clamped to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
- Undefined: shifted value is truncated to its low OUT_WIDTH bits, two's-complement wrap.
- Identical results whenever the shifted value fits in OUT_WIDTH.

Test Plan:
- Group 5,-3,10 (first on 5, last on 10), out_ready=1 -> one cycle after last: out=12, out_valid=1, beat_count_out=3, no errors.
- Single beat -7 with first&last, OUT_SHIFT=0 -> out=-7, beat_count_out=1. Next cycle starts a new group 1,1 -> out=2 two cycles later.
- out_ready=0; two back-to-back groups {4} and {9} -> out stays 4, overrun_err=1. Then out_ready=1 -> out_valid drops, 9 never appears.
- Valid beat without first in IDLE, then first in mid-group {3, first 8, last 2} -> protocol_err=1, out=10 (group restarted at 8).
- OUT_WIDTH=8, sum 100+100=200: with ACCUM_OUT_SATURATE_EN -> out=127; without -> out=-56. OUT_SHIFT=2 on -9 -> out=-3.
- Assert rst_in during an open group {50,50}, release, then send {1, last 1} -> out=2, out_valid=0 during reset, flags 0.

Source files
------------

// File: rtl/adder_tree_accumulator_if.sv
// adder_tree_accumulator_if: root-sum input beats and valid/ready result output
interface adder_tree_accumulator_if #(
  parameter int IN_WIDTH = 38,
  parameter int OUT_WIDTH = 32
);
  logic signed [IN_WIDTH-1:0] sum_in;
  logic sum_valid_in;
  logic sum_first_in;
  logic sum_last_in;
  logic signed [OUT_WIDTH-1:0] out;
  logic out_valid;
  logic out_ready;
  modport master (
    output sum_in, sum_valid_in, sum_first_in, sum_last_in, out_ready,
    input out, out_valid
  );
  modport slave (
    input sum_in, sum_valid_in, sum_first_in, sum_last_in, out_ready,
    output out, out_valid
  );
endinterface

// File: rtl/adder_tree_accumulator.sv
// adder_tree_accumulator: accumulates first/last delimited root sums, emits shifted result on valid/ready
// ACCUM_OUT_SATURATE_EN clamps the shifted result to OUT_WIDTH instead of wrapping
module adder_tree_accumulator #(
  parameter int IN_WIDTH = 38,
  parameter int ACC_WIDTH = 48,
  parameter int OUT_WIDTH = 32,
  parameter int OUT_SHIFT = 0,
  parameter int CNT_WIDTH = 16
) (
  input logic clk,
  input logic rst_in,
  adder_tree_accumulator_if.slave bus,
  output logic [CNT_WIDTH-1:0] beat_count_out,
  output logic busy_out,
  output logic overrun_err_out,
  output logic protocol_err_out
);
  typedef enum logic {IDLE, ACCUM} state_t;
  state_t state;
  logic signed [ACC_WIDTH-1:0] acc, sum_ext, fin, shifted;
  logic signed [OUT_WIDTH-1:0] result;
  logic emit;
  assign sum_ext = ACC_WIDTH'(bus.sum_in);
  // a first beat always restarts the group, even when one is already open
  assign fin = bus.sum_first_in ? sum_ext : acc + sum_ext;
  assign emit = bus.sum_valid_in && bus.sum_last_in && (bus.sum_first_in || state == ACCUM);
  assign shifted = fin >>> OUT_SHIFT;
`ifdef ACCUM_OUT_SATURATE_EN
  localparam logic signed [ACC_WIDTH-1:0] max_v = {{(ACC_WIDTH-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  assign result = shifted > max_v ? OUT_WIDTH'(max_v) : shifted < ~max_v ? OUT_WIDTH'(~max_v) : OUT_WIDTH'(shifted);
`else
  assign result = OUT_WIDTH'(shifted);
`endif
  assign busy_out = bus.out_valid && !bus.out_ready;
  always_ff @(posedge clk)
    if (rst_in) begin
      state <= IDLE;
      acc <= '0;
      bus.out <= '0;
      bus.out_valid <= 1'b0;
      beat_count_out <= '0;
      overrun_err_out <= 1'b0;
      protocol_err_out <= 1'b0;
    end else begin
      if (bus.sum_valid_in) begin
        if (bus.sum_first_in) begin
          protocol_err_out <= protocol_err_out || state == ACCUM;
          beat_count_out <= CNT_WIDTH'(1);
          state <= bus.sum_last_in ? IDLE : ACCUM;
        end else if (state == ACCUM) begin
          beat_count_out <= beat_count_out + CNT_WIDTH'(beat_count_out != '1);
          state <= bus.sum_last_in ? IDLE : ACCUM;
        end else
          protocol_err_out <= 1'b1;
        acc <= fin;
      end
      if (emit && (!bus.out_valid || bus.out_ready)) begin
        bus.out <= result;
        bus.out_valid <= 1'b1;
      end else if (emit)
        overrun_err_out <= 1'b1;
      else if (bus.out_ready)
        bus.out_valid <= 1'b0;
    end
endmodule

// File: tb/tb_adder_tree_accumulator.sv
// tb_adder_tree_accumulator: scoreboard bench driving three configurations with identical beats
module tb_adder_tree_accumulator;
  logic clk = 1'b0;
  logic rst_in = 1'b1;
  always #5 clk = ~clk;
  adder_tree_accumulator_if #(.IN_WIDTH(38), .OUT_WIDTH(32)) bus_a ();
  adder_tree_accumulator_if #(.IN_WIDTH(38), .OUT_WIDTH(8)) bus_b ();
  adder_tree_accumulator_if #(.IN_WIDTH(38), .OUT_WIDTH(16)) bus_c ();
  assign bus_b.sum_in = bus_a.sum_in;
  assign bus_b.sum_valid_in = bus_a.sum_valid_in;
  assign bus_b.sum_first_in = bus_a.sum_first_in;
  assign bus_b.sum_last_in = bus_a.sum_last_in;
  assign bus_b.out_ready = bus_a.out_ready;
  assign bus_c.sum_in = bus_a.sum_in;
  assign bus_c.sum_valid_in = bus_a.sum_valid_in;
  assign bus_c.sum_first_in = bus_a.sum_first_in;
  assign bus_c.sum_last_in = bus_a.sum_last_in;
  assign bus_c.out_ready = bus_a.out_ready;
  logic [15:0] cnt_a, cnt_b;
  logic [2:0] cnt_c;
  logic busy_a, busy_b, busy_c, oerr_a, oerr_b, oerr_c, perr_a, perr_b, perr_c;
  adder_tree_accumulator #(.OUT_WIDTH(32), .OUT_SHIFT(0)) dut_a (
    .clk(clk), .rst_in(rst_in), .bus(bus_a.slave), .beat_count_out(cnt_a),
    .busy_out(busy_a), .overrun_err_out(oerr_a), .protocol_err_out(perr_a));
  adder_tree_accumulator #(.OUT_WIDTH(8), .OUT_SHIFT(0)) dut_b (
    .clk(clk), .rst_in(rst_in), .bus(bus_b.slave), .beat_count_out(cnt_b),
    .busy_out(busy_b), .overrun_err_out(oerr_b), .protocol_err_out(perr_b));
  adder_tree_accumulator #(.OUT_WIDTH(16), .OUT_SHIFT(2), .CNT_WIDTH(3)) dut_c (
    .clk(clk), .rst_in(rst_in), .bus(bus_c.slave), .beat_count_out(cnt_c),
    .busy_out(busy_c), .overrun_err_out(oerr_c), .protocol_err_out(perr_c));
  int passed = 0, total = 0;
  longint qa[$], qb[$], qc[$];
  bit m_open, m_pend, m_perr, m_oerr;
  longint m_acc;
  int m_cnt;
  function automatic longint wrap48(longint x);
    longint r;
    r = x & ((longint'(1) << 48) - 1);
    return r >= (longint'(1) << 47) ? r - (longint'(1) << 48) : r;
  endfunction
  function automatic longint reduce(longint v, int sh, int w);
    longint s, lim, m, r;
    s = v >>> sh;
    lim = longint'(1) << (w - 1);
    m = lim << 1;
    r = s & (m - 1);
`ifdef ACCUM_OUT_SATURATE_EN
    return s >= lim ? lim - 1 : s < -lim ? -lim : s;
`else
    return r >= lim ? r - m : r;
`endif
  endfunction
  task automatic check(string name, longint act, longint exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask
  always @(negedge clk)
    if (!rst_in && bus_a.out_valid && bus_a.out_ready) begin
      if (qa.size() == 0) begin
        total++;
        $display("FAIL out_a: result %0d with no expected entry", bus_a.out);
      end else check("out_a", bus_a.out, reduce(qa.pop_front(), 0, 32));
    end
  always @(negedge clk)
    if (!rst_in && bus_b.out_valid && bus_b.out_ready) begin
      if (qb.size() == 0) begin
        total++;
        $display("FAIL out_b: result %0d with no expected entry", bus_b.out);
      end else check("out_b", bus_b.out, reduce(qb.pop_front(), 0, 8));
    end
  always @(negedge clk)
    if (!rst_in && bus_c.out_valid && bus_c.out_ready) begin
      if (qc.size() == 0) begin
        total++;
        $display("FAIL out_c: result %0d with no expected entry", bus_c.out);
      end else check("out_c", bus_c.out, reduce(qc.pop_front(), 2, 16));
    end
  task automatic step(bit v, bit f, bit l, longint s, bit r);
    bit emit = 1'b0;
    longint fin = 0;
    bus_a.sum_valid_in = v;
    bus_a.sum_first_in = f;
    bus_a.sum_last_in = l;
    bus_a.sum_in = s[37:0];
    bus_a.out_ready = r;
    if (v) begin
      if (f) begin
        if (m_open) m_perr = 1'b1;
        m_cnt = 1;
        m_acc = s;
        m_open = !l;
        emit = l;
        fin = s;
      end else if (m_open) begin
        m_acc = wrap48(m_acc + s);
        m_cnt++;
        m_open = !l;
        emit = l;
        fin = m_acc;
      end else m_perr = 1'b1;
    end
    if (emit && (!m_pend || r)) begin
      qa.push_back(fin);
      qb.push_back(fin);
      qc.push_back(fin);
      m_pend = 1'b1;
    end else if (emit) m_oerr = 1'b1;
    else if (r) m_pend = 1'b0;
    @(posedge clk);
    #1;
    check("beat_count_a", cnt_a, m_cnt > 65535 ? 65535 : m_cnt);
    check("beat_count_c", cnt_c, m_cnt > 7 ? 7 : m_cnt);
    check("out_valid", bus_a.out_valid, m_pend);
    check("busy", busy_a, m_pend && !r);
    check("protocol_err", perr_a, m_perr);
    check("overrun_err", oerr_a, m_oerr);
  endtask
  task automatic do_reset();
    rst_in = 1'b1;
    bus_a.sum_valid_in = 1'b0;
    bus_a.sum_first_in = 1'b0;
    bus_a.sum_last_in = 1'b0;
    bus_a.sum_in = '0;
    bus_a.out_ready = 1'b0;
    qa.delete();
    qb.delete();
    qc.delete();
    {m_open, m_pend, m_perr, m_oerr} = '0;
    m_acc = 0;
    m_cnt = 0;
    @(posedge clk);
    #1;
    check("rst_out_valid", bus_a.out_valid, 0);
    check("rst_out", bus_a.out, 0);
    check("rst_beat_count", cnt_a, 0);
    check("rst_protocol_err", perr_a, 0);
    check("rst_overrun_err", oerr_a, 0);
    check("rst_busy", busy_a, 0);
    rst_in = 1'b0;
  endtask
  initial begin
    do_reset();
    step(1, 1, 0, 5, 1);
    step(1, 0, 0, -3, 1);
    step(1, 0, 1, 10, 1);
    check("group_5_-3_10", bus_a.out, 12);
    step(1, 1, 1, -7, 1);
    check("single_beat", bus_a.out, -7);
    step(1, 1, 0, 1, 1);
    step(1, 0, 1, 1, 1);
    check("group_1_1", bus_a.out, 2);
    step(0, 0, 0, 0, 1);
    step(1, 1, 1, 4, 0);
    step(1, 1, 1, 9, 0);
    check("overrun_held", bus_a.out, 4);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    step(1, 0, 0, 7, 1);
    step(1, 1, 0, 3, 1);
    step(1, 1, 0, 8, 1);
    step(1, 0, 1, 2, 1);
    check("restarted_group", bus_a.out, 10);
    step(1, 1, 0, 100, 1);
    step(1, 0, 1, 100, 1);
`ifdef ACCUM_OUT_SATURATE_EN
    check("narrow_200", bus_b.out, 127);
`else
    check("narrow_200", bus_b.out, -56);
`endif
    step(1, 1, 1, -9, 1);
    check("shift2_-9", bus_c.out, -3);
    step(1, 1, 0, 50, 1);
    step(1, 0, 0, 50, 1);
    do_reset();
    step(1, 1, 0, 1, 1);
    step(1, 0, 1, 1, 1);
    check("after_reset", bus_a.out, 2);
    step(1, 1, 0, 1, 1);
    repeat (9) step(1, 0, 0, 1, 1);
    step(1, 0, 1, 1, 1);
    check("sat_count_c", cnt_c, 7);
    repeat (400) begin
      longint x;
      if ($urandom_range(0, 1) == 0) x = longint'(int'($urandom_range(0, 200)) - 100);
      else begin
        x = {$urandom(), $urandom()};
        x = (x <<< 26) >>> 26;
      end
      step($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0, x,
           $urandom_range(0, 2) != 0);
    end
    repeat (3) step(0, 0, 0, 0, 1);
    check("drained_a", qa.size(), 0);
    check("drained_b", qb.size(), 0);
    check("drained_c", qc.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
